bullet_scheduler: RTL

- Sequences and shares the single bullet datapath between two shooters: player and alien.
- Sits between the game logic (shoot buttons, alien fire, positions) and the bullet block (shoot/posH/enable/clr in; flying/hit out).
- Edge-detects and queues shoot requests, then arbitrates round-robin.
- Launches the bullet, generates its movement tick, tracks the flight to completion or hit, and enforces a cooldown before the next launch.

---
 rtl/bullet_scheduler.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/bullet_scheduler.sv
// ---------------------------------------------------------------------------
// bullet_scheduler
//
// Shares the single bullet datapath between the player and the alien. Rising
// edges on the shoot requests are captured into pending bits, granted
// round-robin, launched into the bullet block, ticked while in flight and
// followed by a fixed cooldown before the next launch.
//
// Ports:
//   clk_i            system clock, all logic on the rising edge
//   reset_i          synchronous active-low reset
//   clr_i            game clear: aborts any flight, drops pending requests
//   run_i            game running: low freezes ticks and holds off grants
//   shoot_p_i        player shoot request (rising edge counts)
//   posH_p_i         player horizontal position
//   shoot_a_i        alien shoot request (rising edge counts)
//   posH_a_i         alien horizontal position
//   flying_i         bullet in flight, from the bullet block
//   hit_i            bullet hit something, from the bullet block
//   bullet_shoot_o   one-cycle launch pulse to the bullet block
//   bullet_posH_o    launch column, held until the next grant
//   bullet_enable_o  one-cycle movement tick
//   bullet_clr_o     one-cycle clear pulse to the bullet block
//   owner_o          0 = player, 1 = alien; valid while busy
//   busy_o           high in LAUNCH, FLIGHT and COOLDOWN
//   hit_p_o          one-cycle pulse: the player's bullet hit
//   hit_a_o          one-cycle pulse: the alien's bullet hit
// ---------------------------------------------------------------------------
module bullet_scheduler #(
    parameter int TICK_DIV       = 4,
    parameter int COOL_CYCLES    = 8,
    parameter int LAUNCH_TIMEOUT = 3
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       clr_i,
    input  logic       run_i,
    input  logic       shoot_p_i,
    input  logic [4:0] posH_p_i,
    input  logic       shoot_a_i,
    input  logic [4:0] posH_a_i,
    input  logic       flying_i,
    input  logic       hit_i,
    output logic       bullet_shoot_o,
    output logic [4:0] bullet_posH_o,
    output logic       bullet_enable_o,
    output logic       bullet_clr_o,
    output logic       owner_o,
    output logic       busy_o,
    output logic       hit_p_o,
    output logic       hit_a_o
);

    localparam int TickW   = $clog2(TICK_DIV);
    localparam int CoolW   = $clog2(COOL_CYCLES + 1);
    localparam int LaunchW = $clog2(LAUNCH_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        FLIGHT,
        COOLDOWN
    } state_e;

    state_e               state_q;
    logic                 shootPPrev_q;
    logic                 shootAPrev_q;
    logic                 pendP_q;
    logic                 pendA_q;
    logic                 lastOwner_q;
    logic                 owner_q;
    logic [4:0]           posH_q;
    logic [TickW-1:0]     tickCnt_q;
    logic [CoolW-1:0]     coolCnt_q;
    logic [LaunchW-1:0]   launchCnt_q;
    logic                 bulletShoot_q;
    logic                 bulletEnable_q;
    logic                 bulletClr_q;
    logic                 hitP_q;
    logic                 hitA_q;

    logic                 inShot;
    logic                 edgeP;
    logic                 edgeA;
    logic                 grant;
    logic                 winner;
    logic                 pendP_d;
    logic                 pendA_d;

    // Request capture and arbitration. An edge from whoever currently owns a
    // launching or flying bullet is thrown away so a player hammering the
    // button cannot queue a follow-up shot. When both are pending, the side
    // that did not fire last wins. A winner's own edge in its grant cycle is
    // swallowed by the grant, and clr drops everything.
    always_comb begin
        inShot  = (state_q == LAUNCH) || (state_q == FLIGHT);
        edgeP   = shoot_p_i & ~shootPPrev_q & ~(inShot & ~owner_q);
        edgeA   = shoot_a_i & ~shootAPrev_q & ~(inShot & owner_q);
        grant   = (state_q == IDLE) & run_i & (pendP_q | pendA_q);
        winner  = (pendP_q & pendA_q) ? ~lastOwner_q : pendA_q;
        pendP_d = pendP_q | edgeP;
        pendA_d = pendA_q | edgeA;
        if (clr_i) begin
            pendP_d = 1'b0;
            pendA_d = 1'b0;
        end else if (grant) begin
            if (winner) begin
                pendA_d = 1'b0;
            end else begin
                pendP_d = 1'b0;
            end
        end
    end

    // Main sequencer. All pulse outputs default low every cycle so none can
    // stretch past one cycle. clr overrides everything below it, including a
    // hit and a grant arriving in the same cycle. In FLIGHT a hit beats a
    // falling flying, so both together still count as a hit.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q        <= IDLE;
            shootPPrev_q   <= 1'b0;
            shootAPrev_q   <= 1'b0;
            pendP_q        <= 1'b0;
            pendA_q        <= 1'b0;
            lastOwner_q    <= 1'b1;
            owner_q        <= 1'b0;
            posH_q         <= 5'd0;
            tickCnt_q      <= '0;
            coolCnt_q      <= '0;
            launchCnt_q    <= '0;
            bulletShoot_q  <= 1'b0;
            bulletEnable_q <= 1'b0;
            bulletClr_q    <= 1'b0;
            hitP_q         <= 1'b0;
            hitA_q         <= 1'b0;
        end else begin
            shootPPrev_q   <= shoot_p_i;
            shootAPrev_q   <= shoot_a_i;
            pendP_q        <= pendP_d;
            pendA_q        <= pendA_d;
            bulletShoot_q  <= 1'b0;
            bulletEnable_q <= 1'b0;
            bulletClr_q    <= 1'b0;
            hitP_q         <= 1'b0;
            hitA_q         <= 1'b0;
            if (clr_i) begin
                bulletClr_q <= inShot;
                state_q     <= IDLE;
                tickCnt_q   <= '0;
                coolCnt_q   <= '0;
                launchCnt_q <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (grant) begin
                            owner_q       <= winner;
                            lastOwner_q   <= winner;
                            posH_q        <= winner ? posH_a_i : posH_p_i;
                            bulletShoot_q <= 1'b1;
                            launchCnt_q   <= '0;
                            state_q       <= LAUNCH;
                        end
                    end
                    LAUNCH: begin
                        // The launch window includes the pulse cycle itself.
                        if (flying_i) begin
                            tickCnt_q <= '0;
                            state_q   <= FLIGHT;
                        end else if (launchCnt_q == LaunchW'(LAUNCH_TIMEOUT - 1)) begin
                            coolCnt_q <= '0;
                            state_q   <= COOLDOWN;
                        end else begin
                            launchCnt_q <= launchCnt_q + LaunchW'(1);
                        end
                    end
                    FLIGHT: begin
                        if (hit_i) begin
                            hitP_q      <= ~owner_q;
                            hitA_q      <= owner_q;
                            bulletClr_q <= 1'b1;
                            coolCnt_q   <= '0;
                            state_q     <= COOLDOWN;
                        end else if (!flying_i) begin
                            coolCnt_q <= '0;
                            state_q   <= COOLDOWN;
                        end else if (run_i) begin
                            if (tickCnt_q == TickW'(TICK_DIV - 1)) begin
                                tickCnt_q      <= '0;
                                bulletEnable_q <= 1'b1;
                            end else begin
                                tickCnt_q <= tickCnt_q + TickW'(1);
                            end
                        end
                    end
                    COOLDOWN: begin
                        if (coolCnt_q == CoolW'(COOL_CYCLES - 1)) begin
                            coolCnt_q <= '0;
                            state_q   <= IDLE;
                        end else begin
                            coolCnt_q <= coolCnt_q + CoolW'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy_o          = (state_q != IDLE);
    assign bullet_shoot_o  = bulletShoot_q;
    assign bullet_posH_o   = posH_q;
    assign bullet_enable_o = bulletEnable_q;
    assign bullet_clr_o    = bulletClr_q;
    assign owner_o         = owner_q;
    assign hit_p_o         = hitP_q;
    assign hit_a_o         = hitA_q;

endmodule
